// File: rtl/anim_pkg.sv
// ============================================================================
// Module   : anim_pkg
// Purpose  : Shared types and constants for the LED-matrix animation
//            sequencer: controller state encoding, animation select
//            encoding, the last frame of each animation, and a lookup helper.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package anim_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    localparam logic [1:0] ANIM_NONE = 2'b00;
    localparam logic [1:0] ANIM_ON   = 2'b01;
    localparam logic [1:0] ANIM_OFF  = 2'b10;
    localparam logic [1:0] ANIM_EGG  = 2'b11;

    localparam logic [4:0] ON_LAST  = 5'd15;
    localparam logic [4:0] OFF_LAST = 5'd8;
    localparam logic [4:0] EGG_LAST = 5'd30;

    // Final frame index of the given animation; ANIM_NONE never plays.
    function automatic logic [4:0] last_frame(input logic [1:0] sel);
        logic [4:0] res;
        case (sel)
            ANIM_ON:  res = ON_LAST;
            ANIM_OFF: res = OFF_LAST;
            ANIM_EGG: res = EGG_LAST;
            default:  res = 5'd0;
        endcase
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/frame_prescaler.sv
// ============================================================================
// Module   : frame_prescaler
// Purpose  : Frame-period timer. Counts 0..FRAME_CYCLES-1 while enabled and
//            wraps; frame_tick is a registered pulse that is high during the
//            cycle in which the count sits at FRAME_CYCLES-1.
// Ports    : clk, reset (sync, active high)
//            clear      - force the count to 0 on the next edge
//            enable     - advance the count on the next edge
//            frame_tick - registered wrap pulse
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module frame_prescaler #(
    parameter int FRAME_CYCLES = 8388608,
    parameter int TMR_W        = 24
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic frame_tick
);

    localparam logic [TMR_W-1:0] CNT_LAST = TMR_W'(FRAME_CYCLES - 1);
    localparam logic [TMR_W-1:0] CNT_PRE  = TMR_W'(FRAME_CYCLES - 2);

    logic [TMR_W-1:0] count_q, count_d;
    logic             tick_q, tick_d;

    // The tick flop is loaded when the count is about to reach its last
    // value, so it is high exactly while count_q == CNT_LAST.
    always_comb begin
        count_d = count_q;
        tick_d  = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = (count_q == CNT_LAST) ? '0 : count_q + TMR_W'(1);
            tick_d  = (count_q == CNT_PRE);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            tick_q  <= tick_d;
        end
    end

    assign frame_tick = tick_q;

endmodule

`default_nettype wire

// File: rtl/anim_sequencer.sv
// ============================================================================
// Module   : anim_sequencer
// Purpose  : Sequencing controller for the 8x8 LED-matrix animations.
//            Arbitrates one-cycle requests (on > off > egg, clear overrides),
//            steps the frame index once per frame period, and holds the last
//            frame until the next request.
// Ports    : clk, reset (sync, active high)
//            req_on/req_off/req_egg/req_clr - one-cycle request pulses
//            anim_sel   - active animation (00 none, 01 on, 10 off, 11 egg)
//            frame      - frame index to the pattern ROMs
//            frame_tick - prescaler wrap pulse
//            busy       - animation playing
//            done       - first cycle of HOLD
//            req_ack    - request accepted (one cycle later)
//            pending    - queued request waiting (queue build only)
// Config   : ANIM_QUEUE_EN - requests during playback are queued in a
//            one-deep slot instead of preempting the current animation.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module anim_sequencer #(
    parameter int FRAME_CYCLES = 8388608,
    parameter int TMR_W        = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_on,
    input  logic       req_off,
    input  logic       req_egg,
    input  logic       req_clr,
    output logic [1:0] anim_sel,
    output logic [4:0] frame,
    output logic       frame_tick,
    output logic       busy,
    output logic       done,
    output logic       req_ack,
    output logic       pending
);

    import anim_pkg::*;

    state_e     state_q, state_d;
    logic [1:0] anim_q, anim_d;
    logic [4:0] frame_q, frame_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       ack_q, ack_d;
    logic       presc_clear, presc_en;
    logic       tick;
    logic       req_any;
    logic [1:0] req_sel;
`ifdef ANIM_QUEUE_EN
    logic       pend_q, pend_d;
    logic [1:0] pend_sel_q, pend_sel_d;
`endif

    frame_prescaler #(
        .FRAME_CYCLES(FRAME_CYCLES),
        .TMR_W       (TMR_W)
    ) u_prescaler (
        .clk       (clk),
        .reset     (reset),
        .clear     (presc_clear),
        .enable    (presc_en),
        .frame_tick(tick)
    );

    assign req_any = req_on | req_off | req_egg;
    assign req_sel = req_on  ? ANIM_ON  :
                     req_off ? ANIM_OFF :
                     req_egg ? ANIM_EGG : ANIM_NONE;

    always_comb begin
        state_d     = state_q;
        anim_d      = anim_q;
        frame_d     = frame_q;
        done_d      = 1'b0;
        ack_d       = 1'b0;
        presc_clear = 1'b1;   // prescaler parked at 0 unless playing on
        presc_en    = 1'b0;
`ifdef ANIM_QUEUE_EN
        pend_d      = pend_q;
        pend_sel_d  = pend_sel_q;
`endif
        if (req_clr) begin
            state_d = ST_IDLE;
            anim_d  = ANIM_NONE;
            frame_d = 5'd0;
`ifdef ANIM_QUEUE_EN
            pend_d     = 1'b0;
            pend_sel_d = ANIM_NONE;
`endif
        end else begin
            case (state_q)
                ST_IDLE, ST_HOLD: begin
                    if (req_any) begin
                        state_d = ST_PLAY;
                        anim_d  = req_sel;
                        frame_d = 5'd0;
                        ack_d   = 1'b1;
`ifdef ANIM_QUEUE_EN
                        pend_d  = 1'b0;   // newer request supersedes queue
                    end else if (pend_q) begin
                        // Queued request was acked when it was stored.
                        state_d = ST_PLAY;
                        anim_d  = pend_sel_q;
                        frame_d = 5'd0;
                        pend_d  = 1'b0;
`endif
                    end
                end
                ST_PLAY: begin
`ifdef ANIM_QUEUE_EN
                    if (req_any) begin
                        pend_d     = 1'b1;
                        pend_sel_d = req_sel;
                        ack_d      = 1'b1;
                    end
                    if (1'b1) begin
`else
                    if (req_any) begin
                        anim_d  = req_sel;
                        frame_d = 5'd0;
                        ack_d   = 1'b1;
                    end else begin
`endif
                        if (tick && (frame_q == last_frame(anim_q))) begin
                            state_d = ST_HOLD;
                            done_d  = 1'b1;
                        end else begin
                            presc_clear = 1'b0;
                            presc_en    = 1'b1;
                            if (tick) begin
                                frame_d = frame_q + 5'd1;
                            end
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    anim_d  = ANIM_NONE;
                    frame_d = 5'd0;
                end
            endcase
        end
        busy_d = (state_d == ST_PLAY);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            anim_q  <= ANIM_NONE;
            frame_q <= 5'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            anim_q  <= anim_d;
            frame_q <= frame_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ack_q   <= ack_d;
        end
    end

`ifdef ANIM_QUEUE_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q     <= 1'b0;
            pend_sel_q <= ANIM_NONE;
        end else begin
            pend_q     <= pend_d;
            pend_sel_q <= pend_sel_d;
        end
    end
    assign pending = pend_q;
`else
    assign pending = 1'b0;
`endif

    assign anim_sel   = anim_q;
    assign frame      = frame_q;
    assign frame_tick = tick;
    assign busy       = busy_q;
    assign done       = done_q;
    assign req_ack    = ack_q;

endmodule

`default_nettype wire

// File: tb/tb_anim_sequencer.sv
// ============================================================================
// Module   : tb_anim_sequencer
// Purpose  : Directed self-checking bench for anim_sequencer with
//            FRAME_CYCLES=4. Expected values are hand-derived cycle numbers.
//            Cycle n means "1 time unit after the n-th rising edge since the
//            last cycle-counter reset"; a request pulse driven in cycle n is
//            sampled at the edge that starts cycle n+1.
//            Covers both builds (ANIM_QUEUE_EN defined or not).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_anim_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_on, req_off, req_egg, req_clr;
    logic [1:0] anim_sel;
    logic [4:0] frame;
    logic       frame_tick, busy, done, req_ack, pending;
    logic [11:0] outs;

    int cyc;
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    anim_sequencer #(
        .FRAME_CYCLES(4),
        .TMR_W       (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_on    (req_on),
        .req_off   (req_off),
        .req_egg   (req_egg),
        .req_clr   (req_clr),
        .anim_sel  (anim_sel),
        .frame     (frame),
        .frame_tick(frame_tick),
        .busy      (busy),
        .done      (done),
        .req_ack   (req_ack),
        .pending   (pending)
    );

    assign outs = {anim_sel, frame, frame_tick, busy, done, req_ack, pending};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got 0x%0h expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic step_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic pulse(input logic on, input logic off, input logic egg, input logic clr);
        req_on = on; req_off = off; req_egg = egg; req_clr = clr;
        step();
        req_on = 1'b0; req_off = 1'b0; req_egg = 1'b0; req_clr = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        req_on = 1'b0; req_off = 1'b0; req_egg = 1'b0; req_clr = 1'b0;
        cyc = 0;
        repeat (3) step();
        reset = 1'b0;

        // Idle after reset: all outputs stay zero.
        for (int i = 0; i < 6; i++) begin
            step();
            check("idle_outs", 32'(outs), 32'h0);
        end

        // Turn-on animation run to HOLD.
        cyc = 0;
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        check("on_ack",   32'(req_ack),  32'd1);
        check("on_sel",   32'(anim_sel), 32'd1);
        check("on_frame0",32'(frame),    32'd0);
        check("on_busy",  32'(busy),     32'd1);
        step_to(3);
        check("on_tick_c3", 32'(frame_tick), 32'd0);
        step_to(4);
        check("on_tick_c4", 32'(frame_tick), 32'd1);
        check("on_frame_c4", 32'(frame), 32'd0);
        step_to(5);
        check("on_frame_c5", 32'(frame), 32'd1);
        check("on_ack_c5",   32'(req_ack), 32'd0);
        step_to(60);
        check("on_frame_c60", 32'(frame), 32'd14);
        step_to(61);
        check("on_frame_c61", 32'(frame), 32'd15);
        step_to(64);
        check("on_done_c64", 32'(done), 32'd0);
        check("on_busy_c64", 32'(busy), 32'd1);
        step_to(65);
        check("on_done_c65", 32'(done), 32'd1);
        check("on_busy_c65", 32'(busy), 32'd0);
        check("on_frame_c65", 32'(frame), 32'd15);
        step_to(70);
        check("on_done_c70",  32'(done),  32'd0);
        check("on_frame_c70", 32'(frame), 32'd15);
        check("on_sel_c70",   32'(anim_sel), 32'd1);

        // Simultaneous requests from HOLD, then clear with a request.
        cyc = 0;
        pulse(1'b1, 1'b1, 1'b1, 1'b0);
        check("arb_sel", 32'(anim_sel), 32'd1);
        check("arb_ack", 32'(req_ack),  32'd1);
        pulse(1'b0, 1'b0, 1'b1, 1'b1);
        check("clr_outs", 32'(outs), 32'h0);
        step();
        check("clr_noack", 32'(outs), 32'h0);

        // Request during PLAY.
        cyc = 0;
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        step_to(3);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
`ifdef ANIM_QUEUE_EN
        check("q_pending", 32'(pending),  32'd1);
        check("q_ack",     32'(req_ack),  32'd1);
        check("q_sel",     32'(anim_sel), 32'd1);
        step_to(64);
        check("q_pend_c64",  32'(pending), 32'd1);
        check("q_frame_c64", 32'(frame),   32'd15);
        check("q_busy_c64",  32'(busy),    32'd1);
        step_to(65);
        check("q_done_c65",  32'(done),    32'd1);
        check("q_busy_c65",  32'(busy),    32'd0);
        check("q_sel_c65",   32'(anim_sel),32'd1);
        check("q_pend_c65",  32'(pending), 32'd1);
        step_to(66);
        check("q_sel_c66",   32'(anim_sel),32'd2);
        check("q_frame_c66", 32'(frame),   32'd0);
        check("q_busy_c66",  32'(busy),    32'd1);
        check("q_pend_c66",  32'(pending), 32'd0);
        check("q_done_c66",  32'(done),    32'd0);
        check("q_ack_c66",   32'(req_ack), 32'd0);
`else
        check("pre_sel",     32'(anim_sel), 32'd2);
        check("pre_frame",   32'(frame),    32'd0);
        check("pre_ack",     32'(req_ack),  32'd1);
        check("pre_pending", 32'(pending),  32'd0);
        step_to(7);
        check("pre_tick_c7",  32'(frame_tick), 32'd1);
        check("pre_frame_c7", 32'(frame),      32'd0);
        step_to(8);
        check("pre_frame_c8", 32'(frame), 32'd1);
`endif
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        check("clr2_outs", 32'(outs), 32'h0);

        // Easter egg to completion, then retrigger from HOLD.
        cyc = 0;
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        check("egg_sel", 32'(anim_sel), 32'd3);
        step_to(121);
        check("egg_frame_c121", 32'(frame), 32'd30);
        check("egg_busy_c121",  32'(busy),  32'd1);
        step_to(125);
        check("egg_done_c125",  32'(done),  32'd1);
        step_to(130);
        check("egg_frame_c130", 32'(frame), 32'd30);
        check("egg_busy_c130",  32'(busy),  32'd0);
        cyc = 0;
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        check("egg2_frame", 32'(frame),   32'd0);
        check("egg2_ack",   32'(req_ack), 32'd1);
        check("egg2_busy",  32'(busy),    32'd1);

        // Reset in the middle of the egg animation.
`ifdef ANIM_QUEUE_EN
        step_to(27);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        check("rst_pend_pre", 32'(pending), 32'd1);
`endif
        step_to(29);
        check("rst_frame_pre", 32'(frame), 32'd7);
        reset = 1'b1;
        step();
        check("rst_outs", 32'(outs), 32'h0);
        reset = 1'b0;
        step();
        check("rst_outs_after", 32'(outs), 32'h0);
        step();
        check("rst_idle_hold", 32'(outs), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/anim_sequencer.md
# anim_sequencer

Sequencing controller for the 8x8 LED matrix animation path. It accepts one-cycle animation requests from the keypad code decoder (turn-on, turn-off, easter egg) and arbitrates simultaneous requests. It times each frame with an internal prescaler, drives the frame index and animation select that feed the pattern ROMs and the row/column time multiplexer, and holds the final frame until the next request.

## Interface
Parameters:
- FRAME_CYCLES, default 8388608: clock cycles per animation frame (minimum 2).
- TMR_W, default 24: prescaler width; must satisfy 2^TMR_W >= FRAME_CYCLES.

Ports:
- clk  input  1  system clock; single clock domain.
- reset  input  1  synchronous, active-high reset.
- req_on  input  1  one-cycle pulse requesting the turn-on animation.
- req_off  input  1  one-cycle pulse requesting the turn-off animation.
- req_egg  input  1  one-cycle pulse requesting the easter-egg animation.
- req_clr  input  1  one-cycle pulse that aborts and blanks the display.
- anim_sel  output  2  active animation: 00 none, 01 on, 10 off, 11 egg.
- frame  output  5  frame index presented to the pattern ROMs.
- frame_tick  output  1  high for the single cycle on which the prescaler wraps.
- busy  output  1  high while in PLAY.
- done  output  1  one-cycle pulse on the first cycle in HOLD.
- req_ack  output  1  one-cycle pulse, one cycle after a request is accepted.
- pending  output  1  a queued request is waiting (ANIM_QUEUE_EN only; otherwise tied to 0).

## Operation
- States: IDLE, PLAY, HOLD.
- **Arbitration.** When more than one request is high in the same cycle, priority is on > off > egg. req_clr overrides all three; any request in that cycle is dropped and not acked.
- **Last frame per animation:** ON_LAST=15, OFF_LAST=8, EGG_LAST=30.
- **IDLE.** anim_sel=00, frame=0. A request moves to PLAY with the matching anim_sel, frame=0 and prescaler=0.
- **PLAY.** The prescaler counts from 0 to FRAME_CYCLES-1 and then wraps.
  - frame_tick is high on the wrap cycle.
  - frame increments on the cycle after frame_tick.
  - If frame==LAST(anim_sel) on a wrap, the block enters HOLD instead and frame stays at LAST.
- **HOLD.** frame holds at LAST and the prescaler is stopped.
  - A new request (any, including the same animation) restarts PLAY at frame 0.
  - req_clr returns the block to IDLE.
- req_clr in PLAY also returns the block to IDLE.
- Reset forces IDLE, and all outputs and pending storage to 0, including in mid-animation.
- No arithmetic wraps on frame: it never exceeds 30.

## Timing
- Request sampled at edge N: at N+1 the state is PLAY, frame=0, anim_sel is valid and req_ack is high.
- Each frame is displayed for exactly FRAME_CYCLES cycles.
- PLAY on an animation with last frame L lasts (L+1)*FRAME_CYCLES cycles. done is asserted on the first HOLD cycle.
- req_clr at edge N gives IDLE, anim_sel=00 and frame=0 at N+1.
- All outputs are registered. No combinational path from inputs to outputs.

## Configuration
- ANIM_QUEUE_EN defined:
  - A request arriving in PLAY is acked and stored in a one-deep pending slot. A later request overwrites it; priority applies within a cycle.
  - The current animation runs to completion. The block is in HOLD for exactly one cycle with done=1, then starts the pending animation at frame 0. pending clears in the same cycle.
  - req_clr also clears the pending slot.
- ANIM_QUEUE_EN undefined:
  - A request in PLAY preempts immediately: restart at frame 0 with the new anim_sel, prescaler=0, acked.
  - pending is tied to 0.

## Structure
- Shared package anim_pkg holds:
  - the state enum;
  - the anim_sel encoding (ANIM_NONE, ANIM_ON, ANIM_OFF, ANIM_EGG);
  - the ON_LAST, OFF_LAST and EGG_LAST constants.
- One sub-module, frame_prescaler: clear/enable inputs, frame_tick output, parameterised by FRAME_CYCLES and TMR_W.

## Test plan
All scenarios use FRAME_CYCLES=4.
- Reset release, no requests: anim_sel=00, frame=0, busy=0 and done=0 are held indefinitely.
- req_on pulse at cycle 0: req_ack at cycle 1; frame increments every 4 cycles; frame=15 at cycle 61; done at cycle 65; frame stays 15 thereafter.
- req_on, req_off and req_egg high together: anim_sel=01. Then req_clr with req_egg in the same cycle: IDLE, no ack.
- req_off in PLAY, macro undefined: restart at frame 0 with anim_sel=10 the next cycle. Same stimulus with the macro defined: pending=1, the ON animation completes, one done cycle, then the OFF animation starts at frame 0.
- req_egg run to completion: frame reaches 30 and holds. req_egg again in HOLD: frame=0 and req_ack the next cycle.
- reset asserted at frame 7 of the egg animation: next cycle all outputs and pending are 0, state IDLE.
